// File: rtl/control_pkg.sv
// Shared types and constants for the CSR SpMV controller.
package control_pkg;

    localparam int CONTROL_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        PTR_START,
        PTR_END,
        NZ_FETCH,
        NZ_MAC,
        EMIT,
        DONE
    } state_e;

endpackage

// File: rtl/control_if.sv
// Memory read ports and row-result stream of the SpMV controller.
interface control_if #(
    parameter int DATA_W = control_pkg::CONTROL_DATA_W
);
    logic [DATA_W-1:0] addr1;
    logic [DATA_W-1:0] dataIn1;
    logic [DATA_W-1:0] addr2;
    logic [DATA_W-1:0] dataIn2;
    logic              out_valid;
    logic [DATA_W-1:0] out_row;
    logic [DATA_W-1:0] out_data;

    modport master (
        output addr1, addr2, out_valid, out_row, out_data,
        input  dataIn1, dataIn2
    );

    modport slave (
        input  addr1, addr2, out_valid, out_row, out_data,
        output dataIn1, dataIn2
    );
endinterface

// File: rtl/spmv_mac.sv
// Row accumulator: clear or add a truncated product, wrapping modulo 2^DATA_W.
module spmv_mac #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [DATA_W-1:0] prod;

    always_comb begin
        // NOTE: acc_d takes its hold value first so no path leaves it unassigned (no latch).
        acc_d = acc_q;
        prod  = a * b;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + prod;
        end
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/control.sv
// CSR sparse-matrix x dense-vector controller; one result per row on bus.out_*.
// Optional CONTROL_PERF_EN adds cycle_cnt / nnz_cnt performance counters.
module control
    import control_pkg::*;
#(
    parameter int DATA_W   = CONTROL_DATA_W,
    parameter int NUM_ROWS = 16,
    parameter int V_SIZE   = 9
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] v_values_base,
    input  logic [DATA_W-1:0] wdata_col_base,
    input  logic [DATA_W-1:0] matrix_base,
    input  logic [DATA_W-1:0] row_base,
    input  logic              RD,
    input  logic [DATA_W-1:0] csize,
    control_if.master         bus,
    output logic              done
`ifdef CONTROL_PERF_EN
    ,
    output logic [DATA_W-1:0] cycle_cnt,
    output logic [DATA_W-1:0] nnz_cnt
`endif
);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
    localparam logic [DATA_W-1:0] LAST_ROW = DATA_W'(NUM_ROWS - 1);

    // V_SIZE is a sizing hint only; it shapes no logic.
    if (V_SIZE < 0) begin : g_v_size_hint
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] row_end_q, row_end_d;
    logic [DATA_W-1:0] col_q, col_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] ptr_clamped;
    logic              acc_clr;
    logic              acc_en;
    logic [DATA_W-1:0] acc;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        k_d         = k_q;
        row_end_d   = row_end_q;
        col_d       = col_q;
        val_d       = val_q;
        done_d      = done_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        bus.addr1   = '0;
        bus.addr2   = '0;
        bus.out_valid = 1'b0;
        ptr_clamped = (bus.dataIn1 > csize) ? csize : bus.dataIn1;

        // Addresses depend only on state, so RD low holds them steady.
        unique case (state_q)
            IDLE: begin
                if (RD) state_d = PTR_START;
            end
            PTR_START: begin
                bus.addr1 = row_base;
                if (RD) begin
                    k_d     = bus.dataIn1;
                    state_d = PTR_END;
                end
            end
            PTR_END: begin
                bus.addr1 = row_base + r_q + ONE;
                if (RD) begin
                    row_end_d = ptr_clamped;
                    acc_clr   = 1'b1;
                    state_d   = (k_q >= ptr_clamped) ? EMIT : NZ_FETCH;
                end
            end
            NZ_FETCH: begin
                bus.addr1 = wdata_col_base + k_q;
                bus.addr2 = matrix_base + k_q;
                if (RD) begin
                    col_d   = bus.dataIn1;
                    val_d   = bus.dataIn2;
                    state_d = NZ_MAC;
                end
            end
            NZ_MAC: begin
                bus.addr2 = v_values_base + col_q;
                if (RD) begin
                    acc_en  = 1'b1;
                    k_d     = k_q + ONE;
                    state_d = (k_q + ONE >= row_end_q) ? EMIT : NZ_FETCH;
                end
            end
            EMIT: begin
                if (RD) begin
                    bus.out_valid = 1'b1;
                    if (r_q == LAST_ROW) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        r_d     = r_q + ONE;
                        state_d = PTR_END;
                    end
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            k_q       <= '0;
            row_end_q <= '0;
            col_q     <= '0;
            val_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            k_q       <= k_d;
            row_end_q <= row_end_d;
            col_q     <= col_d;
            val_q     <= val_d;
            done_q    <= done_d;
        end
    end

    spmv_mac #(.DATA_W(DATA_W)) u_mac (
        .clk (Clk),
        .rst (Rst),
        .clr (acc_clr),
        .en  (acc_en),
        .a   (val_q),
        .b   (bus.dataIn2),
        .acc (acc)
    );

    assign bus.out_row  = r_q;
    assign bus.out_data = acc;
    assign done         = done_q;

`ifdef CONTROL_PERF_EN
    logic [DATA_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [DATA_W-1:0] nnz_cnt_q, nnz_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        nnz_cnt_d   = nnz_cnt_q;
        if (RD && !done_q && state_q != IDLE && state_q != DONE) begin
            cycle_cnt_d = cycle_cnt_q + ONE;
            if (state_q == NZ_MAC) nnz_cnt_d = nnz_cnt_q + ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cycle_cnt_q <= '0;
            nnz_cnt_q   <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            nnz_cnt_q   <= nnz_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign nnz_cnt   = nnz_cnt_q;
`endif
endmodule

// File: tb/tb_control.sv
// Directed bench for control: CSR image in bench memories, results scoreboarded per row.
module tb_control;
    localparam logic [31:0] ROW_BASE = 32'd17470;
    localparam logic [31:0] COL_BASE = 32'd1687;
    localparam logic [31:0] MAT_BASE = 32'd90;
    localparam logic [31:0] V_BASE   = 32'd2;
    localparam logic [31:0] CSIZE    = 32'd77;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd  = 1'b0;
    logic done;
`ifdef CONTROL_PERF_EN
    logic [31:0] cycle_cnt, nnz_cnt;
`endif

    control_if #(.DATA_W(32)) bus ();

    control #(.DATA_W(32), .NUM_ROWS(16), .V_SIZE(9)) dut (
        .Clk            (clk),
        .Rst            (rst),
        .v_values_base  (V_BASE),
        .wdata_col_base (COL_BASE),
        .matrix_base    (MAT_BASE),
        .row_base       (ROW_BASE),
        .RD             (rd),
        .csize          (CSIZE),
        .bus            (bus),
        .done           (done)
`ifdef CONTROL_PERF_EN
        ,
        .cycle_cnt      (cycle_cnt),
        .nnz_cnt        (nnz_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] rp    [17];
    logic [31:0] colm  [78];
    logic [31:0] valm  [78];
    logic [31:0] vv    [16];

    function automatic logic [31:0] mem1(input logic [31:0] a);
        if (a >= ROW_BASE && a < ROW_BASE + 32'd17) return rp[int'(a - ROW_BASE)];
        if (a >= COL_BASE && a < COL_BASE + 32'd78) return colm[int'(a - COL_BASE)];
        return 32'd0;
    endfunction

    function automatic logic [31:0] mem2(input logic [31:0] a);
        if (a >= MAT_BASE && a < MAT_BASE + 32'd78) return valm[int'(a - MAT_BASE)];
        if (a >= V_BASE && a < V_BASE + 32'd16) return vv[int'(a - V_BASE)];
        return 32'd0;
    endfunction

    always_comb begin
        bus.dataIn1 = mem1(bus.addr1);
        bus.dataIn2 = mem2(bus.addr2);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nrec = 0;
    logic [31:0] rec_data [128];
    logic [31:0] rec_row  [128];
    int          rec_cyc  [128];
    logic        rec_done [128];
    int          addr_viol = 0;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && nrec < 128) begin
            rec_data[nrec] <= bus.out_data;
            rec_row[nrec]  <= bus.out_row;
            rec_cyc[nrec]  <= cyc;
            rec_done[nrec] <= done;
            nrec           <= nrec + 1;
        end
        if ((bus.addr1 >= COL_BASE + CSIZE && bus.addr1 < ROW_BASE) ||
            bus.addr2 >= MAT_BASE + CSIZE)
            addr_viol <= addr_viol + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rd  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rec(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (nrec >= n) break;
            tick();
        end
        check("result_timeout", 32'(nrec >= n), 32'd1);
    endtask

    task automatic load_image();
        logic [31:0] ptrs [17];
        logic [31:0] c18 [18];
        logic [31:0] v18 [18];
        logic [31:0] vec [16];
        ptrs = '{0, 7, 12, 18, 22, 22, 27, 32, 37, 42, 47, 52, 57, 62, 67, 72, 78};
        c18  = '{0, 1, 3, 5, 8, 11, 12, 5, 7, 12, 13, 15, 1, 2, 3, 5, 7, 12};
        v18  = '{19, 32, 91, 24, 100, 88, 12, 74, 33, 78, 5, 74, 68, 81, 51, 84, 46, 66};
        vec  = '{26, 67, 31, 89, 16, 22, 20, 68, 23, 53, 10, 88, 40, 90, 6, 50};
        for (int i = 0; i < 17; i++) rp[i] = ptrs[i];
        for (int i = 0; i < 16; i++) vv[i] = vec[i];
        for (int k = 0; k < 78; k++) begin
            if (k < 18) begin
                colm[k] = c18[k];
                valm[k] = v18[k];
            end else begin
                colm[k] = 32'((k * 7) % 16);
                valm[k] = 32'((k * 13) % 97 + 1);
            end
        end
    endtask

    // Reference dot product of one row, row end clamped to csize.
    function automatic logic [31:0] row_sum(input int r);
        logic [31:0] s;
        int st;
        int en;
        s  = 32'd0;
        st = int'(rp[r]);
        en = int'(rp[r + 1]);
        if (en > int'(CSIZE)) en = int'(CSIZE);
        for (int k = st; k < en; k++) s = s + valm[k] * vv[int'(colm[k])];
        return s;
    endfunction

    // Cycle offset of row r's result from the cycle RD was raised.
    function automatic int emit_off(input int r);
        int t;
        int n;
        t = 1;
        for (int j = 0; j <= r; j++) begin
            n = int'(rp[j + 1]);
            if (n > int'(CSIZE)) n = int'(CSIZE);
            n = n - int'(rp[j]);
            if (n < 0) n = 0;
            t = t + 2 + 2 * n;
        end
        return t;
    endfunction

    initial begin
        int base;
        int start;

        // Reset state and idle hold
        load_image();
        do_reset();
        check("rst_addr1", bus.addr1, 32'd0);
        check("rst_addr2", bus.addr2, 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_row", bus.out_row, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        tick();
        tick();
        check("idle_addr1", bus.addr1, 32'd0);

        // Uninterrupted run
        base  = nrec;
        rd    = 1'b1;
        start = cyc;
        wait_rec(base + 16, 400);
        check("row0_data", rec_data[base], 32'd21789);
        check("row1_data", rec_data[base + 1], 32'd11142);
        check("row2_data", rec_data[base + 2], 32'd19222);
        check("row0_cycle", 32'(rec_cyc[base]), 32'(start + 17));
        check("row1_cycle", 32'(rec_cyc[base + 1]), 32'(start + 29));
        check("row2_cycle", 32'(rec_cyc[base + 2]), 32'(start + 43));
        check("empty_row_data", rec_data[base + 4], 32'd0);
        check("empty_row_gap", 32'(rec_cyc[base + 4] - rec_cyc[base + 3]), 32'd2);
        for (int r = 0; r < 16; r++) begin
            check($sformatf("runA_data_r%0d", r), rec_data[base + r], row_sum(r));
            check($sformatf("runA_row_r%0d", r), rec_row[base + r], 32'(r));
            check($sformatf("runA_cyc_r%0d", r), 32'(rec_cyc[base + r]), 32'(start + emit_off(r)));
        end
        check("done_before_last", 32'(rec_done[base + 14]), 32'd0);
        repeat (10) tick();
        check("no_extra_valid", 32'(nrec), 32'(base + 16));
        check("done_sticky", 32'(done), 32'd1);
        check("done_addr1", bus.addr1, 32'd0);
        check("done_addr2", bus.addr2, 32'd0);
        check("csize_clamp", 32'(addr_viol), 32'd0);
`ifdef CONTROL_PERF_EN
        check("perf_cycles", cycle_cnt, 32'd187);
        check("perf_nnz", nnz_cnt, 32'd77);
`endif

        // RD dropped for 5 cycles while row 1 fetches nonzero 8
        do_reset();
        base  = nrec;
        rd    = 1'b1;
        start = cyc;
        repeat (21) tick();
        rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("pause_addr1_%0d", i), bus.addr1, COL_BASE + 32'd8);
            check($sformatf("pause_addr2_%0d", i), bus.addr2, MAT_BASE + 32'd8);
            check($sformatf("pause_valid_%0d", i), 32'(bus.out_valid), 32'd0);
            tick();
        end
        rd = 1'b1;
        wait_rec(base + 16, 400);
        for (int r = 0; r < 16; r++)
            check($sformatf("runB_data_r%0d", r), rec_data[base + r], row_sum(r));
        check("runB_row0_cycle", 32'(rec_cyc[base]), 32'(start + 17));
        check("runB_row1_cycle", 32'(rec_cyc[base + 1]), 32'(start + 34));
        check("runB_row15_cycle", 32'(rec_cyc[base + 15]), 32'(start + emit_off(15) + 5));

        // Reset pulse mid row 2, then rerun
        do_reset();
        rd    = 1'b1;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        check("abort_addr1", bus.addr1, 32'd0);
        check("abort_addr2", bus.addr2, 32'd0);
        check("abort_valid", 32'(bus.out_valid), 32'd0);
        check("abort_row", bus.out_row, 32'd0);
        check("abort_data", bus.out_data, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst   = 1'b0;
        base  = nrec;
        start = cyc;
        wait_rec(base + 1, 100);
        check("rerun_row0_data", rec_data[base], 32'd21789);
        check("rerun_row0_cycle", 32'(rec_cyc[base]), 32'(start + 17));

        // Wrapping product: 0xFFFFFFFF * 2
        do_reset();
        rp[0] = 32'd0;
        for (int i = 1; i < 17; i++) rp[i] = 32'd1;
        colm[0] = 32'd0;
        valm[0] = 32'hFFFF_FFFF;
        vv[0]   = 32'd2;
        base = nrec;
        rd   = 1'b1;
        wait_rec(base + 16, 200);
        check("wrap_row0", rec_data[base], 32'hFFFF_FFFE);
        check("wrap_row1_empty", rec_data[base + 1], 32'd0);
        check("wrap_row15_empty", rec_data[base + 15], 32'd0);
        tick();
        check("wrap_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/control.md
Name: control

Overview:
- CSR sparse-matrix × dense-vector (SpMV) engine for the HHT accelerator; computes y[r] = Σ val[k]·v[col[k]] for each matrix row.
- Drives two combinational-read memory ports:
  - Port 1 (addr1/dataIn1) reads row pointers and column indices.
  - Port 2 (addr2/dataIn2) reads matrix values and vector values.
- Emits one result per row on a valid-qualified output stream.

Parameters:
- DATA_W, 32, width of addresses, data and accumulator
- NUM_ROWS, 16, number of matrix rows processed (row pointer array holds NUM_ROWS+1 entries)
- V_SIZE, 9, vector-length hint; informational only, no effect on behaviour

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  synchronous active-high reset
- v_values_base  in  DATA_W  base address of dense vector v (port 2)
- wdata_col_base  in  DATA_W  base address of column-index array (port 1)
- matrix_base  in  DATA_W  base address of nonzero value array (port 2)
- addr1  out  DATA_W  port-1 read address
- addr2  out  DATA_W  port-2 read address
- dataIn1  in  DATA_W  port-1 read data, valid in the same cycle as addr1
- dataIn2  in  DATA_W  port-2 read data, valid in the same cycle as addr2
- row_base  in  DATA_W  base address of row-pointer array (port 1)
- RD  in  1  run enable; high = process, low = pause
- csize  in  DATA_W  total nonzero count; caps the nonzero index
- out_valid  out  1  one-cycle pulse; a row result is present
- out_row  out  DATA_W  row index of the result
- out_data  out  DATA_W  row dot-product, modulo 2^DATA_W
- done  out  1  sticky; all NUM_ROWS rows have been emitted

Behaviour:
- Memories are asynchronous-read. addr1/addr2 are combinational functions of registered state; dataIn is captured at the same edge.
- Reset: state=IDLE; r=0, k=0, acc=0; out_valid=0, out_row=0, out_data=0, done=0; addr1=addr2=0.
- Base inputs and csize are held stable by the system and are not latched.
- States:
  - IDLE: addr outputs 0. If RD=1, go to PTR_START.
  - PTR_START: addr1=row_base. Latch k=dataIn1. Go to PTR_END.
  - PTR_END: addr1=row_base+r+1. Latch end=min(dataIn1, csize). Clear acc. If k>=end, go to EMIT; else go to NZ_FETCH.
  - NZ_FETCH: addr1=wdata_col_base+k, addr2=matrix_base+k. Latch col=dataIn1, val=dataIn2. Go to NZ_MAC.
  - NZ_MAC: addr2=v_values_base+col. acc += val·dataIn2 (product truncated to DATA_W, wrapping add). k++. If k+1>=end, go to EMIT; else go to NZ_FETCH.
  - EMIT: out_valid=1, out_row=r, out_data=acc. If r==NUM_ROWS-1, set done and go to DONE; else r++ and go to PTR_END. The row start is reused as the previous end.
  - DONE: terminal, addr outputs 0, done=1 until Rst.
- Cost per row: PTR_END 1 cycle + 2 cycles per nonzero + EMIT 1 cycle; row 0 adds PTR_START. An empty row costs 2 cycles and emits 0.
- A row pointer above csize is clamped to csize, so no index ≥ csize is ever read. end<start is treated as an empty row.
- RD=0 in any non-IDLE state freezes all state, addresses and out_valid=0. Processing resumes where it stopped once RD returns high.
- Rst asserted mid-run aborts to reset values in the next cycle.

Optional Feature:
- Macro CONTROL_PERF_EN.
- Defined: adds output ports cycle_cnt (DATA_W) and nnz_cnt (DATA_W), both reset to 0.
  - cycle_cnt increments on every non-IDLE, non-DONE cycle with RD=1.
  - nnz_cnt increments on every NZ_MAC cycle.
  - Both freeze when done is set.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package control_pkg: state enum (IDLE, PTR_START, PTR_END, NZ_FETCH, NZ_MAC, EMIT, DONE) and the DATA_W default constant.
- One sub-module, spmv_mac: registered acc with clear / accumulate-enable, combinational truncated multiply-add.

Test Plan:
- Common memory image for all scenarios:
  - row_base=17470, row ptrs 0,7,12,18,…
  - cols at 1687+k: 0,1,3,5,8,11,12,5,7,12,13,15,1,2,3,5,7,12,…
  - vals at 90+k: 19,32,91,24,100,88,12,74,33,78,5,74,68,81,51,84,46,66,…
  - v at 2..17: 26,67,31,89,16,22,20,68,23,53,10,88,40,90,6,50
  - wdata_col_base=1687, matrix_base=90, v_values_base=2
- Reset then RD=1 with the image above → out_row0=21789, row1=11142, row2=19222. Row-0 out_valid in the 17th cycle after leaving IDLE.
- Last row pointer 78 with csize=77 → no addr1 ≥ wdata_col_base+77 and no addr2 ≥ matrix_base+77 issued; done asserts after row 15.
- Row with ptr[r]==ptr[r+1] → out_data=0 two cycles after the previous EMIT.
- RD dropped for 5 cycles mid-row 1 → addresses frozen, no out_valid; results identical to the uninterrupted run, delayed 5 cycles.
- Rst pulsed mid-run → next cycle all outputs 0 and done=0; rerun reproduces row0=21789.
- Values 0xFFFFFFFF·2 → out_data wraps to 0xFFFFFFFE.
